// File: rtl/acumulador_nzp_pkg.sv
// Shared constants and FSM state type for the batch accumulator.
`timescale 1ns/1ps
package acumulador_nzp_pkg;
  localparam int NBITS_DEF = 8;
  localparam int NOPS_DEF  = 4;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;
endpackage

// File: rtl/acumulador_nzp_soma_ov.sv
// Combinational wrap-around adder with signed-overflow detection.
`timescale 1ns/1ps
module soma_ov #(
  parameter int NBITS = 8
) (
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  output logic [NBITS-1:0] sum,
  output logic             ovf
);
  assign sum = a + b;
  // Overflow only when both operands share a sign the result does not.
  assign ovf = (a[NBITS-1] == b[NBITS-1]) && (sum[NBITS-1] != a[NBITS-1]);
endmodule

// File: rtl/acumulador_nzp.sv
// Batch accumulator: sums NOPS signed operands, then holds the sum with
// N/Z/P/V flags until the consumer takes it.
`timescale 1ns/1ps
module acumulador_nzp
  import acumulador_nzp_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int NOPS  = NOPS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [NBITS-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [NBITS-1:0] S,
  output logic                    N,
  output logic                    Z,
  output logic                    P,
  output logic                    V
);
  localparam int CW = $clog2(NOPS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NOPS - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic [NBITS-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             v_r;
  logic [NBITS-1:0] sum_s;
  logic             ovf_s;
  logic             accept_s;
  logic             clear_s;

  soma_ov #(.NBITS(NBITS)) u_soma (
    .a   (acc_r),
    .b   (in_data),
    .sum (sum_s),
    .ovf (ovf_s)
  );

  // Next-state and handshake decode from the current state.
  always_comb begin
    next_state_s = state_r;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    accept_s     = 1'b0;
    clear_s      = 1'b0;
    case (state_r)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept_s = 1'b1;
          if (cnt_r == LAST_CNT) begin
            next_state_s = DONE;
          end else begin
            next_state_s = ACC;
          end
        end else begin
          next_state_s = ACC;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          clear_s      = 1'b1;
          next_state_s = ACC;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = ACC;
      end
    endcase
  end

  // State, accumulator, operand count and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ACC;
      acc_r   <= {NBITS{1'b0}};
      cnt_r   <= {CW{1'b0}};
      v_r     <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (accept_s) begin
        acc_r <= sum_s;
        cnt_r <= cnt_r + CW'(1);
        v_r   <= v_r | ovf_s;
      end else if (clear_s) begin
        acc_r <= {NBITS{1'b0}};
        cnt_r <= {CW{1'b0}};
        v_r   <= 1'b0;
      end else begin
        acc_r <= acc_r;
        cnt_r <= cnt_r;
        v_r   <= v_r;
      end
    end
  end

  assign S = acc_r;
  assign N = acc_r[NBITS-1];
  assign Z = (acc_r == {NBITS{1'b0}});
  assign P = ~acc_r[0];
  assign V = v_r;
endmodule

// File: tb/tb_acumulador_nzp.sv
// Scoreboard bench for acumulador_nzp: expected batch results are queued by
// the stimulus and checked by a monitor on each output handshake.
`timescale 1ns/1ps
module tb_acumulador_nzp;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] S;
  logic       N, Z, P, V;

  typedef struct packed {
    logic [7:0] s;
    logic       n;
    logic       z;
    logic       p;
    logic       v;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  acumulador_nzp #(.NBITS(8), .NOPS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .N         (N),
    .Z         (Z),
    .P         (P),
    .V         (V)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every output handshake pops one expected batch result.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon_unexpected: got S=%0h expected no result", S);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_S", {24'd0, S}, {24'd0, e.s});
        chk("mon_N", {31'd0, N}, {31'd0, e.n});
        chk("mon_Z", {31'd0, Z}, {31'd0, e.z});
        chk("mon_P", {31'd0, P}, {31'd0, e.p});
        chk("mon_V", {31'd0, V}, {31'd0, e.v});
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] x);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      nxt();
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    nxt();
    in_valid = 1'b0;
  endtask

  task automatic take();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    nxt();
    out_ready = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    @(negedge clk);
    chk({nm, "_S"}, {24'd0, S}, 32'd0);
    chk({nm, "_N"}, {31'd0, N}, 32'd0);
    chk({nm, "_Z"}, {31'd0, Z}, 32'd1);
    chk({nm, "_P"}, {31'd0, P}, 32'd1);
    chk({nm, "_V"}, {31'd0, V}, 32'd0);
    chk({nm, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_idle("reset");
    nxt();

    // Back-to-back batch: 10+20-5+3 = 28.
    exp_q.push_back('{s: 8'd28, n: 1'b0, z: 1'b0, p: 1'b1, v: 1'b0});
    send(8'd10);
    send(8'd20);
    send(8'hFB);
    send(8'd3);
    @(negedge clk);
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd0);
    nxt();
    take();
    chk_idle("after_take1");
    nxt();

    // Overflow batch: 100+50 -> -106 (V), -30 -> 120 (V), -120 -> 0.
    exp_q.push_back('{s: 8'd0, n: 1'b0, z: 1'b1, p: 1'b1, v: 1'b1});
    send(8'd100);
    send(8'd50);
    @(negedge clk);
    chk("ovf_mid_S", {24'd0, S}, 32'h96);
    chk("ovf_mid_N", {31'd0, N}, 32'd1);
    chk("ovf_mid_V", {31'd0, V}, 32'd1);
    nxt();
    send(8'hE2);
    @(negedge clk);
    chk("ovf_3rd_S", {24'd0, S}, 32'h78);
    chk("ovf_3rd_out_valid", {31'd0, out_valid}, 32'd0);
    nxt();
    send(8'h88);

    // Backpressure with a pending operand that must be ignored.
    in_valid = 1'b1;
    in_data  = 8'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_S", {24'd0, S}, 32'd0);
      chk("bp_Z", {31'd0, Z}, 32'd1);
      chk("bp_V", {31'd0, V}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      nxt();
    end
    take();
    chk_idle("after_take2");
    nxt();

    // Gapped input: four -1 operands with idle cycles between.
    exp_q.push_back('{s: 8'hFC, n: 1'b1, z: 1'b0, p: 1'b1, v: 1'b0});
    send(8'hFF);
    nxt();
    send(8'hFF);
    nxt();
    @(negedge clk);
    chk("gap_hold_S", {24'd0, S}, 32'hFE);
    nxt();
    send(8'hFF);
    nxt();
    send(8'hFF);
    @(negedge clk);
    chk("gap_out_valid", {31'd0, out_valid}, 32'd1);
    nxt();
    take();
    chk_idle("after_take3");
    nxt();

    // Reset mid-batch discards the partial sum.
    send(8'd5);
    send(8'd6);
    @(negedge clk);
    chk("mid_S", {24'd0, S}, 32'd11);
    nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    chk_idle("mid_reset");
    nxt();
    exp_q.push_back('{s: 8'd4, n: 1'b0, z: 1'b0, p: 1'b1, v: 1'b0});
    for (int i = 0; i < 4; i++) send(8'd1);
    take();
    chk_idle("after_take4");
    nxt();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
